// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared states, direction/pattern constants and step pattern lookup for gate_seq_encoder
package gate_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_S1    = 3'd2,
        ST_S2    = 3'd3,
        ST_S3    = 3'd4,
        ST_FAULT = 3'd5,
        ST_TAIL  = 3'd6
    } state_e;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // Patterns are {a,b}.
    localparam logic [1:0] PAT_00 = 2'b00;
    localparam logic [1:0] PAT_10 = 2'b10;
    localparam logic [1:0] PAT_11 = 2'b11;
    localparam logic [1:0] PAT_01 = 2'b01;

    // Step 0 is the LEAD/TAIL idle pattern, steps 1..3 walk the Gray sequence.
    function automatic logic [1:0] step_pattern(input logic dir, input logic [1:0] step);
        logic [1:0] pat;
        case (step)
            2'd1:    pat = (dir == DIR_ENTER) ? PAT_10 : PAT_01;
            2'd2:    pat = PAT_11;
            2'd3:    pat = (dir == DIR_ENTER) ? PAT_01 : PAT_10;
            default: pat = PAT_00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/gate_seq_dwell_timer.sv
// rtl/gate_seq_dwell_timer.sv - loadable down-counter; expire_o is high for the one cycle the count is 1
module gate_seq_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Parks at zero once expired so expire_o cannot repeat without a reload.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/gate_seq_encoder.sv
// rtl/gate_seq_encoder.sv - two-sensor gate sequence transmitter; GATE_SEQ_JITTER_EN adds LFSR dwell jitter
module gate_seq_encoder
    import gate_seq_pkg::*;
#(
    parameter int          DWELL_W   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_dir,
    input  logic               req_fault,
    input  logic [1:0]         req_fault_depth,
    input  logic [DWELL_W-1:0] req_dwell,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic               inc_exp,
    output logic               dec_exp,
    output logic [2:0]         dbg_state
);

`ifdef GATE_SEQ_JITTER_EN
    localparam int TMR_W = DWELL_W + 1;
`else
    localparam int TMR_W = DWELL_W;
`endif

    state_e             state_q, state_d;
    logic [1:0]         ab_q, ab_d;
    logic               dir_q, fault_q;
    logic [1:0]         depth_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               done_q, inc_q, dec_q;

    logic               accept, expire, advance, done_d, tmr_load;
    logic [1:0]         step_idx;
    logic [DWELL_W-1:0] req_dwell_eff, base_dwell;
    logic [TMR_W-1:0]   tmr_value;

    assign accept        = req_valid && (state_q == ST_IDLE);
    assign advance       = expire && (state_q != ST_IDLE);
    assign req_dwell_eff = (req_dwell == '0) ? DWELL_W'(1) : req_dwell;
    assign base_dwell    = accept ? req_dwell_eff : dwell_q;
    assign tmr_load      = accept || (advance && state_q != ST_TAIL);
    assign done_d        = advance && (state_q == ST_TAIL);

`ifdef GATE_SEQ_JITTER_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign tmr_value = {1'b0, base_dwell} + {{(TMR_W-4){1'b0}}, lfsr_q[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (tmr_load) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`else
    assign tmr_value = base_dwell;
`endif

    gate_seq_dwell_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .expire_o (expire)
    );

    always_comb begin
        case (state_q)
            ST_S1:   step_idx = 2'd1;
            ST_S2:   step_idx = 2'd2;
            ST_S3:   step_idx = 2'd3;
            default: step_idx = 2'd0;
        endcase
    end

    // A fault replaces the step after `depth` legal steps with the inverse of the held pattern.
    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LEAD;
                    ab_d    = PAT_00;
                end
            end
            ST_LEAD, ST_S1, ST_S2, ST_S3: begin
                if (advance) begin
                    if (fault_q && depth_q == step_idx) begin
                        state_d = ST_FAULT;
                        ab_d    = ~ab_q;
                    end else if (step_idx == 2'd3) begin
                        state_d = ST_TAIL;
                        ab_d    = PAT_00;
                    end else begin
                        state_d = (state_q == ST_LEAD) ? ST_S1 :
                                  (state_q == ST_S1)   ? ST_S2 : ST_S3;
                        ab_d    = step_pattern(dir_q, step_idx + 2'd1);
                    end
                end
            end
            ST_FAULT: begin
                if (advance) begin
                    state_d = ST_TAIL;
                    ab_d    = PAT_00;
                end
            end
            ST_TAIL: begin
                if (advance) begin
                    state_d = ST_IDLE;
                    ab_d    = PAT_00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ab_d    = PAT_00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ab_q    <= PAT_00;
            done_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            dir_q   <= DIR_ENTER;
            fault_q <= 1'b0;
            depth_q <= 2'd0;
            dwell_q <= DWELL_W'(1);
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            done_q  <= done_d;
            inc_q   <= done_d && !fault_q && (dir_q == DIR_ENTER);
            dec_q   <= done_d && !fault_q && (dir_q == DIR_EXIT);
            if (accept) begin
                dir_q   <= req_dir;
                fault_q <= req_fault;
                depth_q <= req_fault_depth;
                dwell_q <= req_dwell_eff;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign done      = done_q;
    assign inc_exp   = inc_q;
    assign dec_exp   = dec_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_seq_encoder.sv
// tb/tb_gate_seq_encoder.sv - randomized self-checking bench for gate_seq_encoder against a pattern-list model
module tb_gate_seq_encoder;
    import gate_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_dir;
    logic        req_fault;
    logic [1:0]  req_fault_depth;
    logic [15:0] req_dwell;
    logic        a, b, busy, done, inc_exp, dec_exp;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int inc_seen = 0;
    int dec_seen = 0;
    int done_seen = 0;

    logic [1:0] exp_q[$];

    gate_seq_encoder #(.DWELL_W(16), .LFSR_SEED(16'hACE1)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dir         (req_dir),
        .req_fault       (req_fault),
        .req_fault_depth (req_fault_depth),
        .req_dwell       (req_dwell),
        .a               (a),
        .b               (b),
        .busy            (busy),
        .done            (done),
        .inc_exp         (inc_exp),
        .dec_exp         (dec_exp),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inc_exp) inc_seen++;
        if (dec_exp) dec_seen++;
        if (done) done_seen++;
    end

    // Expected list of held patterns, one entry per state, LEAD through TAIL.
    function automatic void model_seq(input bit dir, input bit fault, input int depth);
        logic [1:0] steps[3];
        int n;
        exp_q.delete();
        if (dir) begin
            steps[0] = 2'b01; steps[1] = 2'b11; steps[2] = 2'b10;
        end else begin
            steps[0] = 2'b10; steps[1] = 2'b11; steps[2] = 2'b01;
        end
        exp_q.push_back(2'b00);
        n = fault ? depth : 3;
        for (int i = 0; i < n; i++) exp_q.push_back(steps[i]);
        if (fault) exp_q.push_back(~exp_q[exp_q.size()-1]);
        exp_q.push_back(2'b00);
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_fault = 1'b0;
        req_fault_depth = 2'd0; req_dwell = 16'd1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({a, b, busy, done, inc_exp, dec_exp} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000", {a, b, busy, done, inc_exp, dec_exp});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", req_ready);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_sequences();
        bit dir_t[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bit fault_t[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int depth_t[6] = '{0, 0, 0, 3, 0, 1};
        int dwell_t[6] = '{4, 3, 2, 2, 0, 1};
        for (int r = 0; r < 30; r++) begin
            bit dir, fault;
            int depth, dwell, d, total;
            if (r < 6) begin
                dir = dir_t[r]; fault = fault_t[r]; depth = depth_t[r]; dwell = dwell_t[r];
            end else begin
                dir = 1'($urandom); fault = 1'($urandom); depth = $urandom_range(0, 3);
                dwell = $urandom_range(0, 6);
            end
            @(posedge clk);
            #1 req_valid = 1'b1; req_dir = dir; req_fault = fault;
            req_fault_depth = 2'(depth); req_dwell = 16'(dwell);
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("FAIL seq%0d_ready got=%b want=1", r, req_ready);
            end
            @(posedge clk);
            #1 req_valid = 1'b0; req_dir = ~dir; req_fault = ~fault;
            req_fault_depth = 2'($urandom); req_dwell = 16'($urandom_range(7, 40));
            model_seq(dir, fault, depth);
            d = (dwell == 0) ? 1 : dwell;
            total = exp_q.size() * d;
            for (int c = 1; c <= total; c++) begin
                @(negedge clk);
                checks++;
                if ({a, b} !== exp_q[(c-1)/d] || busy !== 1'b1 || {done, inc_exp, dec_exp} !== 3'b0) begin
                    failures++;
                    $display("FAIL seq%0d_cycle%0d got ab=%b busy=%b pulses=%b want ab=%b busy=1 pulses=000",
                             r, c, {a, b}, busy, {done, inc_exp, dec_exp}, exp_q[(c-1)/d]);
                end
            end
            @(negedge clk);
            checks++;
            if ({done, inc_exp, dec_exp} !== {1'b1, !fault && !dir, !fault && dir} ||
                {a, b, busy} !== 3'b000 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL seq%0d_done got done/inc/dec=%b ab_busy=%b ready=%b want %b 000 1",
                         r, {done, inc_exp, dec_exp}, {a, b, busy}, req_ready,
                         {1'b1, !fault && !dir, !fault && dir});
            end
        end
    endtask

    task automatic test_reset_mid();
        int start_done, start_inc;
        @(posedge clk);
        #1 req_valid = 1'b1; req_dir = 1'b0; req_fault = 1'b0; req_fault_depth = 2'd0; req_dwell = 16'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (7) @(posedge clk);
        checks++;
        if ({a, b} !== 2'b11) begin
            failures++;
            $display("FAIL midreset_in_s2 got ab=%b want=11", {a, b});
        end
        start_done = done_seen; start_inc = inc_seen;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({a, b, busy, req_ready, done} !== 5'b00010) begin
            failures++;
            $display("FAIL midreset_after got a,b,busy,ready,done=%b want=00010", {a, b, busy, req_ready, done});
        end
        repeat (15) @(negedge clk);
        checks++;
        if (done_seen != start_done || inc_seen != start_inc) begin
            failures++;
            $display("FAIL midreset_pulses got done=%0d inc=%0d want done=%0d inc=%0d",
                     done_seen - start_done, inc_seen - start_inc, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        int dw[N];
        int exp_inc = 0, exp_dec = 0;
        for (int j = 0; j < N; j++) dw[j] = $urandom_range(1, 3);
        @(posedge clk);
        #1 inc_seen = 0; dec_seen = 0;
        req_valid = 1'b1; req_dir = 1'b0; req_fault = 1'b0; req_dwell = 16'(dw[0]);
        @(posedge clk);
        for (int j = 0; j < N; j++) begin
            bit dir;
            int total;
            dir = j[0];
            if (dir) exp_dec++; else exp_inc++;
            #1;
            if (j < N - 1) begin
                req_dir = ~dir; req_dwell = 16'(dw[j+1]);
            end else begin
                req_valid = 1'b0;
            end
            model_seq(dir, 1'b0, 0);
            total = exp_q.size() * dw[j];
            for (int c = 1; c <= total; c++) begin
                @(negedge clk);
                checks++;
                if ({a, b} !== exp_q[(c-1)/dw[j]] || busy !== 1'b1 ||
                    (c == 1 && dbg_state !== ST_LEAD)) begin
                    failures++;
                    $display("FAIL b2b%0d_cycle%0d got ab=%b busy=%b state=%0d want ab=%b busy=1",
                             j, c, {a, b}, busy, dbg_state, exp_q[(c-1)/dw[j]]);
                end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b%0d_done got done=%b ready=%b want 1 1", j, done, req_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (inc_seen != exp_inc || dec_seen != exp_dec || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_counts got inc=%0d dec=%0d busy=%b want inc=%0d dec=%0d busy=0",
                     inc_seen, dec_seen, busy, exp_inc, exp_dec);
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
